// File: rtl/dht11_controle_leitura.sv
// Periodic read controller for the dht11 block: triggers reads, waits with a
// timeout, retries failures and holds the last good temperature/humidity words.
module dht11_controle_leitura #(
    parameter int PERIODO_CICLOS = 100_000_000,
    parameter int TIMEOUT_CICLOS = 1_500_000,
    parameter int PAUSA_CICLOS   = 50_000_000,
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        habilita,
    input  logic        medir,
    input  logic        dht_pronto,
    input  logic        dht_error,
    input  logic [15:0] dht_temperatura,
    input  logic [15:0] dht_umidade,
    output logic        dht_start,
    output logic [15:0] temperatura,
    output logic [15:0] umidade,
    output logic        dado_valido,
    output logic        novo_dado,
    output logic        falha,
    output logic [3:0]  db_estado
);

    localparam int W_PER   = (PERIODO_CICLOS > 1) ? $clog2(PERIODO_CICLOS) : 1;
    localparam int W_TO    = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int W_PAUSA = (PAUSA_CICLOS   > 1) ? $clog2(PAUSA_CICLOS)   : 1;
    localparam int W_TENT  = (MAX_TENTATIVAS > 1) ? $clog2(MAX_TENTATIVAS) : 1;

    localparam logic [W_PER-1:0]   PER_FIM   = W_PER'(PERIODO_CICLOS - 1);
    localparam logic [W_TO-1:0]    TO_FIM    = W_TO'(TIMEOUT_CICLOS - 1);
    localparam logic [W_PAUSA-1:0] PAUSA_FIM = W_PAUSA'(PAUSA_CICLOS - 1);
    localparam logic [W_TENT-1:0]  TENT_FIM  = W_TENT'(MAX_TENTATIVAS - 1);

    typedef enum logic [3:0] {
        OCIOSO   = 4'd0,
        DISPARA  = 4'd1,
        AGUARDA  = 4'd2,
        ARMAZENA = 4'd3,
        REPETE   = 4'd4,
        PAUSA    = 4'd5,
        FALHA    = 4'd6
    } estado_t;

    estado_t r_estado;
    estado_t w_proximo;

    logic [W_PER-1:0]   r_cnt_per;
    logic [W_TO-1:0]    r_cnt_to;
    logic [W_PAUSA-1:0] r_cnt_pausa;
    logic [W_TENT-1:0]  r_tent;
    logic               r_pronto_d;
    logic               r_error_d;
    logic [15:0]        r_temp;
    logic [15:0]        r_umid;
    logic               r_valido;
    logic               r_falha;

    logic w_pronto_borda;
    logic w_error_borda;
    logic w_fim_per;
    logic w_fim_to;
    logic w_fim_pausa;
    logic w_ult_tent;

    // Only fresh edges count, so a level left high by an earlier read is ignored.
    assign w_pronto_borda = dht_pronto & ~r_pronto_d;
    assign w_error_borda  = dht_error  & ~r_error_d;
    assign w_fim_per      = habilita && (r_cnt_per == PER_FIM);
    assign w_fim_to       = (r_cnt_to == TO_FIM);
    assign w_fim_pausa    = (r_cnt_pausa == PAUSA_FIM);
    assign w_ult_tent     = (r_tent == TENT_FIM);

    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned, which is what keeps this block from inferring latches.
    always_comb begin
        w_proximo = r_estado;
        dht_start = 1'b0;
        novo_dado = 1'b0;
        case (r_estado)
            OCIOSO:   if (medir || w_fim_per) w_proximo = DISPARA;
            DISPARA: begin
                dht_start = 1'b1;
                w_proximo = AGUARDA;
            end
            AGUARDA: begin
                if (w_error_borda)       w_proximo = REPETE;
                else if (w_pronto_borda) w_proximo = ARMAZENA;
                else if (w_fim_to)       w_proximo = REPETE;
            end
            ARMAZENA: begin
                novo_dado = 1'b1;
                w_proximo = OCIOSO;
            end
            REPETE:   w_proximo = w_ult_tent ? FALHA : PAUSA;
            PAUSA:    if (w_fim_pausa) w_proximo = DISPARA;
            FALHA:    w_proximo = OCIOSO;
            default:  w_proximo = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= OCIOSO;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt_per   <= '0;
            r_cnt_to    <= '0;
            r_cnt_pausa <= '0;
            r_tent      <= '0;
            r_pronto_d  <= 1'b0;
            r_error_d   <= 1'b0;
            r_temp      <= '0;
            r_umid      <= '0;
            r_valido    <= 1'b0;
            r_falha     <= 1'b0;
        end else begin
            r_pronto_d <= dht_pronto;
            r_error_d  <= dht_error;

            // Period count restarts on every entry to OCIOSO and whenever disabled.
            if (r_estado == OCIOSO && w_proximo == OCIOSO && habilita)
                r_cnt_per <= r_cnt_per + W_PER'(1);
            else
                r_cnt_per <= '0;

            if (r_estado == AGUARDA) r_cnt_to <= r_cnt_to + W_TO'(1);
            else                     r_cnt_to <= '0;

            if (r_estado == PAUSA) r_cnt_pausa <= r_cnt_pausa + W_PAUSA'(1);
            else                   r_cnt_pausa <= '0;

            if (r_estado == OCIOSO)
                r_tent <= '0;
            else if (r_estado == REPETE && !w_ult_tent)
                r_tent <= r_tent + W_TENT'(1);

            // Capture on the same edge that samples the pronto edge.
            if (r_estado == AGUARDA && w_proximo == ARMAZENA) begin
                r_temp   <= dht_temperatura;
                r_umid   <= dht_umidade;
                r_valido <= 1'b1;
                r_falha  <= 1'b0;
            end else if (r_estado == REPETE && w_proximo == FALHA) begin
                r_falha <= 1'b1;
            end
        end
    end

    assign temperatura = r_temp;
    assign umidade     = r_umid;
    assign dado_valido = r_valido;
    assign falha       = r_falha;
    assign db_estado   = r_estado;

endmodule

// File: tb/tb_dht11_controle_leitura.sv
// Self-checking bench: directed read scenarios from a table plus random
// response sequences, checked against a timing/outcome model of the controller.
`timescale 1ns/1ps
module tb_dht11_controle_leitura;

    localparam int PERIODO = 100;
    localparam int TIMEOUT = 50;
    localparam int PAUSA   = 20;
    localparam int MAX     = 3;

    localparam logic [1:0] R_NADA   = 2'd0;
    localparam logic [1:0] R_ERRO   = 2'd1;
    localparam logic [1:0] R_PRONTO = 2'd2;
    localparam logic [1:0] R_AMBOS  = 2'd3;

    typedef struct {
        string           nome;
        logic [2:0][1:0] resp;
        logic [2:0][7:0] dly;
        logic [15:0]     temp;
        logic [15:0]     umid;
        logic            medir_em_aguarda;
        int              exp_starts;
        logic            exp_falha;
        logic            exp_valido;
        logic [15:0]     exp_temp;
        logic [15:0]     exp_umid;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        habilita = 1'b0;
    logic        medir = 1'b0;
    logic        dht_pronto = 1'b0;
    logic        dht_error = 1'b0;
    logic [15:0] dht_temperatura = '0;
    logic [15:0] dht_umidade = '0;
    logic        dht_start;
    logic [15:0] temperatura;
    logic [15:0] umidade;
    logic        dado_valido;
    logic        novo_dado;
    logic        falha;
    logic [3:0]  db_estado;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] mdl_t = '0;
    logic [15:0] mdl_u = '0;
    logic        mdl_v = 1'b0;

    vec_t tabela [6];

    dht11_controle_leitura #(
        .PERIODO_CICLOS(PERIODO),
        .TIMEOUT_CICLOS(TIMEOUT),
        .PAUSA_CICLOS  (PAUSA),
        .MAX_TENTATIVAS(MAX)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .habilita       (habilita),
        .medir          (medir),
        .dht_pronto     (dht_pronto),
        .dht_error      (dht_error),
        .dht_temperatura(dht_temperatura),
        .dht_umidade    (dht_umidade),
        .dht_start      (dht_start),
        .temperatura    (temperatura),
        .umidade        (umidade),
        .dado_valido    (dado_valido),
        .novo_dado      (novo_dado),
        .falha          (falha),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_checks++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nome, atual, esperado, cyc);
        end
    endtask

    function automatic vec_t mk(input string n, input logic [1:0] r0, r1, r2,
                                input int d0, d1, d2, input logic [15:0] t, u,
                                input int es, input logic ef, input logic [15:0] et, eu);
        vec_t v;
        v.nome = n;
        v.resp[0] = r0; v.resp[1] = r1; v.resp[2] = r2;
        v.dly[0] = 8'(d0); v.dly[1] = 8'(d1); v.dly[2] = 8'(d2);
        v.temp = t; v.umid = u;
        v.medir_em_aguarda = 1'b0;
        v.exp_starts = es; v.exp_falha = ef; v.exp_valido = 1'b1;
        v.exp_temp = et; v.exp_umid = eu;
        return v;
    endfunction

    task automatic wait_start(input int budget, output int s);
        s = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (dht_start === 1'b1) begin
                s = cyc;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL start_espera: no dht_start within %0d cycles (cycle %0d)", budget, cyc);
    endtask

    // medir driven in cycle c is sampled at the end of c, so DISPARA is cycle c+1.
    task automatic dispara_medir(output int exp_s);
        @(negedge clock);
        medir = 1'b1;
        exp_s = cyc + 1;
        @(posedge clock);
        #1 medir = 1'b0;
    endtask

    // Attempt resolved in cycle r: success shows in r+1, retry start at r+PAUSA+2,
    // final failure flagged in r+2.
    task automatic do_read(input vec_t v, input int exp_s0, output int fim);
        int s, r, exp_s, n_starts;
        logic [1:0] tp;
        exp_s = exp_s0;
        n_starts = 0;
        fim = -1;
        for (int k = 0; k < MAX; k++) begin
            wait_start(400, s);
            if (s < 0) return;
            n_starts++;
            check({v.nome, "/start_ciclo"}, s, exp_s);
            tp = v.resp[k];
            if (tp == R_NADA) begin
                r = s + TIMEOUT;
            end else begin
                r = s + int'(v.dly[k]);
                for (int j = 1; j <= int'(v.dly[k]); j++) begin
                    @(negedge clock);
                    if (j == 1) begin
                        check({v.nome, "/start_pulso"}, dht_start, 0);
                        check({v.nome, "/estado_aguarda"}, db_estado, 2);
                    end
                    if (v.medir_em_aguarda && j == 2) medir = 1'b1;
                    if (j == 3) medir = 1'b0;
                end
                dht_pronto      = (tp == R_PRONTO || tp == R_AMBOS);
                dht_error       = (tp == R_ERRO || tp == R_AMBOS);
                dht_temperatura = (tp == R_PRONTO) ? v.temp : ~v.temp;
                dht_umidade     = (tp == R_PRONTO) ? v.umid : ~v.umid;
            end
            if (tp == R_PRONTO) begin
                @(negedge clock);
                check({v.nome, "/novo_dado"}, novo_dado, 1);
                check({v.nome, "/temperatura"}, temperatura, v.exp_temp);
                check({v.nome, "/umidade"}, umidade, v.exp_umid);
                check({v.nome, "/dado_valido"}, dado_valido, v.exp_valido);
                check({v.nome, "/falha"}, falha, v.exp_falha);
                dht_pronto = 1'b0;
                @(negedge clock);
                check({v.nome, "/novo_dado_fim"}, novo_dado, 0);
                fim = r + 1;
                break;
            end
            if (tp != R_NADA) begin
                @(negedge clock);
                dht_pronto = 1'b0;
                dht_error  = 1'b0;
            end
            if (k == MAX - 1) begin
                while (cyc < r + 2) @(negedge clock);
                check({v.nome, "/falha"}, falha, v.exp_falha);
                check({v.nome, "/estado_falha"}, db_estado, 6);
                check({v.nome, "/temperatura_mantida"}, temperatura, v.exp_temp);
                check({v.nome, "/umidade_mantida"}, umidade, v.exp_umid);
                check({v.nome, "/dado_valido"}, dado_valido, v.exp_valido);
                fim = r + 2;
            end else begin
                exp_s = r + PAUSA + 2;
            end
        end
        check({v.nome, "/n_starts"}, n_starts, v.exp_starts);
    endtask

    task automatic conta_starts(input int ciclos, input string nome);
        int n;
        n = 0;
        for (int i = 0; i < ciclos; i++) begin
            @(negedge clock);
            if (dht_start === 1'b1) n++;
        end
        check(nome, n, 0);
    endtask

    task automatic check_zerado(input string nome);
        check({nome, "/dht_start"}, dht_start, 0);
        check({nome, "/temperatura"}, temperatura, 0);
        check({nome, "/umidade"}, umidade, 0);
        check({nome, "/dado_valido"}, dado_valido, 0);
        check({nome, "/novo_dado"}, novo_dado, 0);
        check({nome, "/falha"}, falha, 0);
        check({nome, "/db_estado"}, db_estado, 0);
    endtask

    initial begin
        int es, fim;
        vec_t vp;

        tabela[0] = mk("manual",      R_PRONTO, R_NADA,  R_NADA,   10, 1,  1,  16'h1900, 16'h3C00, 1, 1'b0, 16'h1900, 16'h3C00);
        tabela[1] = mk("retry_ok",    R_ERRO,   R_AMBOS, R_PRONTO, 7,  12, 15, 16'h1A05, 16'h4100, 3, 1'b0, 16'h1A05, 16'h4100);
        tabela[2] = mk("exausto",     R_NADA,   R_NADA,  R_NADA,   1,  1,  1,  16'hDEAD, 16'hBEEF, 3, 1'b1, 16'h1A05, 16'h4100);
        tabela[3] = mk("recupera",    R_PRONTO, R_NADA,  R_NADA,   1,  1,  1,  16'h0102, 16'h0304, 1, 1'b0, 16'h0102, 16'h0304);
        tabela[4] = mk("pronto_tarde", R_PRONTO, R_NADA, R_NADA,   TIMEOUT, 1, 1, 16'hFFFF, 16'h0000, 1, 1'b0, 16'hFFFF, 16'h0000);
        tabela[5] = mk("erro_borda",  R_ERRO,   R_ERRO,  R_ERRO,   1, TIMEOUT, 25, 16'h5555, 16'hAAAA, 3, 1'b1, 16'hFFFF, 16'h0000);

        #2 reset = 1'b0;
        #1 check_zerado("reset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        conta_starts(500, "ocioso_sem_start");

        for (int i = 0; i < 6; i++) begin
            dispara_medir(es);
            do_read(tabela[i], es, fim);
            mdl_t = tabela[i].exp_temp;
            mdl_u = tabela[i].exp_umid;
            mdl_v = tabela[i].exp_valido;
            repeat (3) @(negedge clock);
        end

        // Periodic reads: medir starts the first, the period counter the rest.
        habilita = 1'b1;
        vp = mk("periodo0", R_PRONTO, R_NADA, R_NADA, 10, 1, 1, 16'h2000, 16'h3000, 1, 1'b0, 16'h2000, 16'h3000);
        dispara_medir(es);
        do_read(vp, es, fim);
        vp = mk("periodo1", R_PRONTO, R_NADA, R_NADA, 8, 1, 1, 16'h2111, 16'h3111, 1, 1'b0, 16'h2111, 16'h3111);
        vp.medir_em_aguarda = 1'b1;
        do_read(vp, fim + PERIODO + 1, fim);
        vp = mk("periodo2", R_PRONTO, R_NADA, R_NADA, 30, 1, 1, 16'h2222, 16'h3222, 1, 1'b0, 16'h2222, 16'h3222);
        do_read(vp, fim + PERIODO + 1, fim);
        habilita = 1'b0;
        mdl_t = 16'h2222;
        mdl_u = 16'h3222;
        mdl_v = 1'b1;
        conta_starts(150, "habilita_zero_sem_start");

        for (int n = 0; n < 15; n++) begin
            vec_t v;
            int succ;
            v.nome = "aleatorio";
            v.medir_em_aguarda = 1'b0;
            for (int k = 0; k < MAX; k++) begin
                v.resp[k] = 2'($urandom_range(0, 3));
                v.dly[k]  = 8'($urandom_range(1, TIMEOUT));
            end
            v.temp = 16'($urandom);
            v.umid = 16'($urandom);
            succ = -1;
            for (int k = 0; k < MAX; k++)
                if (succ < 0 && v.resp[k] == R_PRONTO) succ = k;
            if (succ >= 0) begin
                v.exp_starts = succ + 1;
                v.exp_falha  = 1'b0;
                v.exp_valido = 1'b1;
                v.exp_temp   = v.temp;
                v.exp_umid   = v.umid;
            end else begin
                v.exp_starts = MAX;
                v.exp_falha  = 1'b1;
                v.exp_valido = mdl_v;
                v.exp_temp   = mdl_t;
                v.exp_umid   = mdl_u;
            end
            repeat ($urandom_range(0, 4)) @(negedge clock);
            dispara_medir(es);
            do_read(v, es, fim);
            mdl_t = v.exp_temp;
            mdl_u = v.exp_umid;
            mdl_v = v.exp_valido;
            repeat (2) @(negedge clock);
        end

        // Reset in the middle of AGUARDA, followed by a late pronto edge.
        dispara_medir(es);
        wait_start(10, fim);
        repeat (5) @(negedge clock);
        check("reset_meio/estado_aguarda", db_estado, 2);
        reset = 1'b0;
        #1 check_zerado("reset_meio");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        dht_pronto      = 1'b1;
        dht_temperatura = 16'hABCD;
        dht_umidade     = 16'h1234;
        @(negedge clock);
        dht_pronto = 1'b0;
        repeat (2) @(negedge clock);
        check_zerado("pos_reset");
        conta_starts(150, "pos_reset_sem_start");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dht11_controle_leitura.md
# dht11_controle_leitura

Periodic read controller that sits directly downstream of `dht11`. It triggers the sensor's `start`, waits for `pronto`/`error` with a timeout, and retries failed reads. It latches the last good temperature/humidity words and presents them to the rest of the design with a valid flag, a new-data strobe and a sticky failure flag.

## Interface
- `PERIODO_CICLOS`, 100_000_000: idle cycles between the end of a read and the next automatic read (2 s at 50 MHz).
- `TIMEOUT_CICLOS`, 1_500_000: maximum cycles spent waiting for `dht11` to answer (30 ms).
- `PAUSA_CICLOS`, 50_000_000: gap before a retry (1 s).
- `MAX_TENTATIVAS`, 3: attempts per read before declaring failure (≥1).

Ports:
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low.
- `habilita` in 1: enables periodic automatic reads.
- `medir` in 1: one-cycle manual read request; honoured only in OCIOSO; works regardless of `habilita`.
- `dht_pronto` in 1: from `dht11.pronto`.
- `dht_error` in 1: from `dht11.error`.
- `dht_temperatura` in 16: from `dht11.temperatura`.
- `dht_umidade` in 16: from `dht11.umidade`.
- `dht_start` out 1: one-cycle pulse to `dht11.start`.
- `temperatura` out 16: last good temperature.
- `umidade` out 16: last good humidity.
- `dado_valido` out 1: high after the first successful read since reset.
- `novo_dado` out 1: one-cycle pulse per successful read.
- `falha` out 1: sticky; set when retries are exhausted, cleared by the next success.
- `db_estado` out 4: state code.

## Operation
- Reset values:
  - All outputs 0.
  - State OCIOSO; all counters 0.
  - Registered copies of `dht_pronto`/`dht_error` are 0.
- Edge detection: `dht_pronto` and `dht_error` act only on rising edges (input high, registered copy low), and only in AGUARDA. Levels held from a previous read are ignored.
- States (`db_estado` code in parentheses):
  - OCIOSO (0): clears the attempt counter.
    - Period counter increments while `habilita`=1 and is forced to 0 while `habilita`=0.
    - Goes to DISPARA when `medir`=1, or when the counter equals PERIODO_CICLOS-1 with `habilita`=1.
  - DISPARA (1): `dht_start`=1 for this cycle only; clears the timeout counter; goes to AGUARDA.
  - AGUARDA (2): timeout counter increments each cycle.
    - Error edge goes to REPETE. An error edge has priority over a simultaneous pronto edge.
    - Else a pronto edge goes to ARMAZENA, capturing `dht_temperatura`/`dht_umidade` on that same clock edge.
    - Else, when the timeout counter equals TIMEOUT_CICLOS-1, goes to REPETE.
  - ARMAZENA (3): `novo_dado`=1; `dado_valido` set; `falha` cleared; goes to OCIOSO with the period counter at 0.
  - REPETE (4): if attempts = MAX_TENTATIVAS-1, goes to FALHA; else increments attempts and goes to PAUSA with the pause counter at 0.
  - PAUSA (5): counts PAUSA_CICLOS cycles, then goes to DISPARA.
  - FALHA (6): `falha` set; goes to OCIOSO with the period counter at 0.
- `medir` outside OCIOSO is dropped, not queued.
- `temperatura`/`umidade` change only on a successful capture. Failures never alter them or `dado_valido`.
- Counter widths are sized by `$clog2` of their parameter. Counters never wrap, because each one is compared for equality and reset on exit.

## Timing
- `dht_start` is high exactly one cycle after `medir` is sampled high in OCIOSO.
- Capture latency: `temperatura`, `umidade` and `novo_dado` are valid in the cycle after the clock edge at which the `dht_pronto` rising edge is sampled.
- Automatic spacing: the next `dht_start` occurs exactly PERIODO_CICLOS+1 cycles after `novo_dado` (or after the FALHA cycle).
- Timeout retry spacing: consecutive `dht_start` pulses are TIMEOUT_CICLOS+PAUSA_CICLOS+2 cycles apart.
- `falha` rises in the cycle following the final REPETE.
- Reset asserted mid-read returns everything to reset values immediately. No `dht_start` is issued until a new trigger arrives.

## Test plan
Bench parameters: PERIODO=100, TIMEOUT=50, PAUSA=20, MAX=3.
- Reset check: after `reset`=0 → all outputs 0 and `db_estado`=0. With `habilita`=0 and no `medir` for 500 cycles → no `dht_start`.
- Manual read: `medir` pulse; bench raises `dht_pronto` 10 cycles after `dht_start` with 0x1900/0x3C00 → `temperatura`=0x1900, `umidade`=0x3C00, one `novo_dado` pulse, `dado_valido`=1, `falha`=0.
- Periodic reads: `habilita`=1 and the bench answers every request → `dht_start` pulses exactly 101 cycles after each `novo_dado`. `medir` pulsed during AGUARDA → ignored.
- Retry then success: `dht_error` edge on attempts 1 and 2, `dht_pronto` with 0x1A05/0x4100 on attempt 3 → three `dht_start` pulses, data updated, `falha`=0. Simultaneous pronto+error edges count as an error.
- Exhausted retries: after a good read, no response → three `dht_start` pulses 72 cycles apart, then `falha`=1. Previous data and `dado_valido`=1 are held. The next success clears `falha`.
- Reset mid-AGUARDA: `reset`=0 for 2 cycles during AGUARDA, then a late `dht_pronto` edge arrives → no capture, state OCIOSO, all outputs 0.
